stopwatch_cu: RTL and testbench

Control unit for the stopwatch datapath. It takes three raw push-buttons (run/stop, clear, lap), then synchronizes, debounces and edge-detects each one. A Moore FSM then produces the run and clear controls for the 100 Hz tick divider and the downstream time counters, plus a lap_hold signal that freezes the display while counting continues. It sits between the board buttons and the clk_div/counter/FND datapath.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/stopwatch_if.sv | 21 ++
 rtl/btn_debounce.sv | 49 ++++
 rtl/stopwatch_cu.sv | 73 +++++++
 tb/tb_stopwatch_cu.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch control unit: FSM state encoding and
// button index map used by the debounce array.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_RUN   = 2'd1,
      ST_LAP   = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   localparam int NUM_BTN      = 3;
   localparam int BTN_RUN_STOP = 0;
   localparam int BTN_CLEAR    = 1;
   localparam int BTN_LAP      = 2;

endpackage

// File: rtl/stopwatch_if.sv
// Button inputs and control outputs of the stopwatch control unit.
// The control unit is the slave; the board/bench side is the master.
interface stopwatch_if;
   logic       btn_run_stop;
   logic       btn_clear;
   logic       btn_lap;
   logic       run;
   logic       clear;
   logic       lap_hold;
   logic [1:0] state_o;

   modport slave (
      input  btn_run_stop, btn_clear, btn_lap,
      output run, clear, lap_hold, state_o
   );

   modport master (
      output btn_run_stop, btn_clear, btn_lap,
      input  run, clear, lap_hold, state_o
   );
endinterface

// File: rtl/btn_debounce.sv
// One raw push-button to a single-cycle press pulse: 2-FF synchronizer,
// consecutive-cycle debounce counter, and rising-edge detect on the stable level.
module btn_debounce #(
   parameter int DEBOUNCE_CNT = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_in,
   output logic btn_pulse
);

   localparam int             CNT_W    = $clog2(DEBOUNCE_CNT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_stable;
   logic             r_stable_prev;
   logic             r_pulse;
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_sync1       <= 1'b0;
         r_sync2       <= 1'b0;
         r_stable      <= 1'b0;
         r_stable_prev <= 1'b0;
         r_pulse       <= 1'b0;
         r_cnt         <= '0;
      end else begin
         r_sync1       <= btn_in;
         r_sync2       <= r_sync1;
         r_stable_prev <= r_stable;
         r_pulse       <= r_stable & ~r_stable_prev;
         // any agreement with the stable level restarts the count
         if (r_sync2 == r_stable) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign btn_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_cu.sv
// Stopwatch control unit: three debounced buttons drive a Moore FSM that
// produces run / clear / lap_hold for the tick divider and time counters.
//
//  state | meaning
//  STOP  | counters halted, display live
//  RUN   | counters running, display live
//  LAP   | counters running, display frozen
//  CLEAR | one-cycle clear pulse, then back to STOP
module stopwatch_cu
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CNT = 1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   stopwatch_if.slave  sw
);

   logic [NUM_BTN-1:0] w_btn_raw;
   logic [NUM_BTN-1:0] w_pulse;
   state_t             r_state;
   state_t             w_state_nxt;

   assign w_btn_raw[BTN_RUN_STOP] = sw.btn_run_stop;
   assign w_btn_raw[BTN_CLEAR]    = sw.btn_clear;
   assign w_btn_raw[BTN_LAP]      = sw.btn_lap;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_debounce (
         .clk       (clk),
         .reset     (reset),
         .btn_in    (w_btn_raw[g]),
         .btn_pulse (w_pulse[g])
      );
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_STOP;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // run_stop is tested first in every state, giving run_stop > clear > lap
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_STOP: begin
            if (w_pulse[BTN_RUN_STOP])   w_state_nxt = ST_RUN;
            else if (w_pulse[BTN_CLEAR]) w_state_nxt = ST_CLEAR;
         end
         ST_RUN: begin
            if (w_pulse[BTN_RUN_STOP]) w_state_nxt = ST_STOP;
            else if (w_pulse[BTN_LAP]) w_state_nxt = ST_LAP;
         end
         ST_LAP: begin
            if (w_pulse[BTN_RUN_STOP]) w_state_nxt = ST_STOP;
            else if (w_pulse[BTN_LAP]) w_state_nxt = ST_RUN;
         end
         ST_CLEAR: w_state_nxt = ST_STOP;
         default:  w_state_nxt = ST_STOP;
      endcase
   end

   assign sw.run      = (r_state == ST_RUN) || (r_state == ST_LAP);
   assign sw.clear    = (r_state == ST_CLEAR);
   assign sw.lap_hold = (r_state == ST_LAP);
   assign sw.state_o  = r_state;

endmodule

// File: tb/tb_stopwatch_cu.sv
// Bench for stopwatch_cu with DEBOUNCE_CNT=4: directed scenarios followed by
// random button traffic, all checked each cycle against a window-based model.
module tb_stopwatch_cu;

   localparam int D    = 4;
   localparam int MAXC = 8192;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_errors;

   stopwatch_if sw ();

   stopwatch_cu #(
      .DEBOUNCE_CNT (D)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .sw    (sw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // model: per-edge history of raw samples and resets
   bit raw_h [3][MAXC];
   int n;
   int last_rst;
   bit m_stable [3];
   int last_flip [3];
   int rise_edge [3];
   int m_state;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
      end
   endtask

   // synchronized level seen by the debounce logic just before edge k
   function automatic bit s_at(input int b, input int k);
      if (k - 2 > last_rst) return raw_h[b][k-2];
      return 1'b0;
   endfunction

   function automatic int next_state(input int s, input bit rs, input bit cl, input bit lp);
      case (s)
         0:       return rs ? 1 : (cl ? 3 : 0);
         1:       return rs ? 0 : (lp ? 2 : 1);
         2:       return rs ? 0 : (lp ? 1 : 2);
         default: return 0;
      endcase
   endfunction

   task automatic model_edge(input bit rst_act);
      bit p [3];
      bit all_diff;
      if (rst_act) begin
         last_rst = n;
         m_state  = 0;
         for (int b = 0; b < 3; b++) begin
            m_stable[b]  = 1'b0;
            last_flip[b] = n;
            rise_edge[b] = -100;
         end
         return;
      end
      // a debounced rise at edge k shows as a pulse after k+1 and acts at k+2
      for (int b = 0; b < 3; b++) p[b] = (rise_edge[b] == n - 2);
      m_state = next_state(m_state, p[0], p[1], p[2]);
      for (int b = 0; b < 3; b++) begin
         if (n - last_flip[b] >= D) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
               if (s_at(b, n - j) == m_stable[b]) all_diff = 1'b0;
            if (all_diff) begin
               m_stable[b]  = ~m_stable[b];
               last_flip[b] = n;
               if (m_stable[b]) rise_edge[b] = n;
            end
         end
      end
   endtask

   task automatic step(input bit rst_n, input bit rs, input bit cl, input bit lp);
      @(negedge clk);
      reset           = rst_n;
      sw.btn_run_stop = rs;
      sw.btn_clear    = cl;
      sw.btn_lap      = lp;
      n++;
      raw_h[0][n] = rs;
      raw_h[1][n] = cl;
      raw_h[2][n] = lp;
      @(posedge clk);
      model_edge(~rst_n);
      #1;
      chk("run",      int'(sw.run),      int'(m_state == 1 || m_state == 2));
      chk("clear",    int'(sw.clear),    int'(m_state == 3));
      chk("lap_hold", int'(sw.lap_hold), int'(m_state == 2));
      chk("state_o",  int'(sw.state_o),  m_state);
   endtask

   task automatic press(input bit rs, input bit cl, input bit lp, input int hold, input int gap);
      for (int i = 0; i < hold; i++) step(1'b1, rs, cl, lp);
      for (int i = 0; i < gap; i++)  step(1'b1, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      int lvl [3];
      int seg [3];
      int rcnt;
      bit rv;
      n_checks = 0;
      n_errors = 0;
      n = 0;
      last_rst = 0;
      m_state = 0;
      for (int b = 0; b < 3; b++) begin
         m_stable[b] = 1'b0; last_flip[b] = 0; rise_edge[b] = -100;
         lvl[b] = 0; seg[b] = 0;
      end
      reset = 1'b0;
      sw.btn_run_stop = 1'b0;
      sw.btn_clear    = 1'b0;
      sw.btn_lap      = 1'b0;

      // 1: reset with all buttons high, then run_stop held through release
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("rst_state", int'(sw.state_o), 0);
      chk("rst_run", int'(sw.run), 0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b1, 1'b0, 0);
         if (i == 7) chk("t1_edge7_state", int'(sw.state_o), 0);
         if (i == 8) chk("t1_edge8_run", int'(sw.run), 1);
      end
      press(0, 0, 0, 0, 10);

      // 2: stop, start with latency check, stop, clear pulse
      press(1, 0, 0, 10, 10);
      chk("t2_stopped", int'(sw.state_o), 0);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b1, 1'b0, 1'b0);
         if (i == 7) chk("t2_edge7_run", int'(sw.run), 0);
         if (i == 8) chk("t2_edge8_run", int'(sw.run), 1);
      end
      press(0, 0, 0, 0, 10);
      press(1, 0, 0, 10, 10);
      for (int i = 1; i <= 10; i++) begin
         step(1'b1, 1'b0, 1'b1, 1'b0);
         if (i == 8) chk("t2_clear_hi", int'(sw.clear), 1);
         if (i == 9) chk("t2_clear_lo", int'(sw.clear), 0);
         if (i == 9) chk("t2_after_clear", int'(sw.state_o), 0);
      end
      press(0, 0, 0, 0, 10);

      // 3: lap glitch, lap, unlap
      press(1, 0, 0, 6, 10);
      press(0, 0, 1, 3, 12);
      chk("t3_glitch", int'(sw.lap_hold), 0);
      press(0, 0, 1, 6, 10);
      chk("t3_lap_hold", int'(sw.lap_hold), 1);
      chk("t3_lap_run", int'(sw.run), 1);
      press(0, 0, 1, 6, 10);
      chk("t3_unlap", int'(sw.state_o), 1);

      // 4: simultaneous presses
      press(0, 0, 1, 6, 10);
      press(1, 0, 1, 6, 10);
      chk("t4_rs_beats_lap", int'(sw.state_o), 0);
      chk("t4_lap_hold", int'(sw.lap_hold), 0);
      press(1, 1, 0, 6, 10);
      chk("t4_rs_beats_clear", int'(sw.state_o), 1);

      // 5: clear ignored while running and in lap
      press(0, 1, 0, 6, 10);
      chk("t5_run_clear", int'(sw.state_o), 1);
      press(0, 0, 1, 6, 10);
      press(0, 1, 0, 6, 10);
      chk("t5_lap_clear", int'(sw.state_o), 2);

      // 6: reset in LAP mid-debounce
      press(1, 0, 0, 3, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6_rst_state", int'(sw.state_o), 0);
      chk("t6_rst_run", int'(sw.run), 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      press(0, 0, 0, 0, 12);
      chk("t6_no_stale", int'(sw.state_o), 0);

      // random traffic with occasional resets
      rcnt = 0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (seg[b] == 0) begin
               lvl[b] = 1 - lvl[b];
               seg[b] = int'($urandom_range(1, 12));
            end
            seg[b]--;
         end
         if (rcnt > 0) rcnt--;
         else if ($urandom_range(0, 299) == 0) rcnt = int'($urandom_range(1, 3));
         rv = (rcnt == 0);
         step(rv, lvl[0] != 0, lvl[1] != 0, lvl[2] != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
